mac_dot_acc: RTL and testbench
==============================

// Module: mac_dot_acc
// PURPOSE
//  Parametrised, pipelined multiply-accumulate engine; successor to the single-register MAC.
//  Accepts a stream of (A,B) terms framed by IN_VALID/LAST and accumulates A*B per frame.
//  Emits one result per frame with a valid pulse, term count and overflow flag.
//  Sits between operand sources and result consumers in the MAC datapath; no backpressure.
// PARAMETERS
//  IN1_WIDTH   4   width of operand A
//  IN2_WIDTH   4   width of operand B
//  OUT_WIDTH   12  accumulator/result width; must be >= IN1_WIDTH+IN2_WIDTH (elaboration check)
//  CNT_WIDTH   8   width of term counter
//  SIGNED      0   0: operands unsigned; 1: operands two's complement
// PORTS
//  SYS_CLK    in   1          single clock, all state on rising edge
//  SYS_RST_N  in   1          asynchronous, active-low reset
//  SCLR       in   1          synchronous clear / pipeline flush
//  IN_VALID   in   1          A,B (and LAST) valid this cycle
//  LAST       in   1          qualified by IN_VALID: final term of frame
//  A          in   IN1_WIDTH  operand A
//  B          in   IN2_WIDTH  operand B
//  MAC_OUT    out  OUT_WIDTH  result of last completed frame; held until next result
//  OUT_VALID  out  1          one-cycle pulse when MAC_OUT updates
//  TERM_CNT   out  CNT_WIDTH  number of terms in last completed frame
//  OVF        out  1          overflow occurred in last completed frame
// BEHAVIOUR
//  - Reset (SYS_RST_N=0): immediately clear all registers; MAC_OUT=0, OUT_VALID=0, TERM_CNT=0, OVF=0, FSM=IDLE.
//  - Stage 1 (edge after sampling): register P = A*B (IN1+IN2 bits, signed iff SIGNED), plus valid/LAST.
//  - Stage 2 (next edge): accumulate; FSM lives here. P sign-/zero-extended to OUT_WIDTH.
//  - FSM IDLE: stage-1 valid -> ACC=P, cnt=1, ovf=0; LAST ? emit, stay IDLE : go ACCUM.
//  - FSM ACCUM: stage-1 valid -> ACC=ACC+P, cnt+=1 (saturates at 2^CNT_WIDTH-1); LAST ? emit, go IDLE.
//  - Emit: MAC_OUT<=new ACC, TERM_CNT<=cnt, OVF<=ovf, OUT_VALID<=1 for exactly one cycle.
//  - Latency: LAST term sampled at edge n -> OUT_VALID/MAC_OUT visible after edge n+2.
//  - Throughput 1 term/cycle; next frame may start the cycle after LAST with no bubble.
//  - IN_VALID=0 cycles inside a frame: ACC and cnt hold. LAST without IN_VALID ignored.
//  - Arithmetic: without saturation, wrap modulo 2^OUT_WIDTH.
//  - SCLR=1: at next edge flush stage 1, ACC=0, cnt=0, FSM=IDLE, MAC_OUT=0, TERM_CNT=0, OVF=0, OUT_VALID=0;
//    SCLR wins over IN_VALID same cycle; aborted frame never emits; terms sampled while SCLR=1 discarded.
//  - Reset mid-frame: frame discarded, no OUT_VALID after release.
// CONFIGURATION
//  MAC_SAT_EN defined: sum formed at OUT_WIDTH+1 bits; result outside range clamps
//    (unsigned: 2^W-1; signed: 2^(W-1)-1 / -2^(W-1)); later terms continue from clamped value;
//    ovf sets sticky for rest of frame, reported on OVF at emit.
//  MAC_SAT_EN undefined: wrap-around arithmetic, OVF tied 0, no saturation logic.
// TESTING
//  1. Async reset low mid-frame -> all outputs 0 same cycle; no OUT_VALID after release.
//  2. Unsigned (3,5),(2,7),(15,15) LAST on 3rd -> 2 cycles later OUT_VALID=1, MAC_OUT=254, TERM_CNT=3.
//  3. Single term A=4,B=6 LAST, next frame A=1,B=1 LAST next cycle -> 24 then 1 on consecutive cycles.
//  4. Frame with idle gaps then SCLR before LAST -> no OUT_VALID; next frame (2,2) LAST -> MAC_OUT=4.
//  5. SIGNED=1: A=4'b1000(-8),B=7 LAST -> MAC_OUT=12'hFC8 (-56), OVF=0.
//  6. OUT_WIDTH=8 unsigned (15,15),(15,15) LAST -> no MAC_SAT_EN: MAC_OUT=194,OVF=0; MAC_SAT_EN: 255,OVF=1.

Source files
------------

// File: rtl/mac_dot_acc_if.sv
// mac_dot_acc_if: operand/result bundle for the dot-product MAC.
//   master: operand source; drives IN_VALID, LAST, A, B and observes the results.
//   slave : the MAC; samples IN_VALID, LAST, A, B and drives MAC_OUT, OUT_VALID,
//           TERM_CNT, OVF.
// Widths must match the parameters of the attached mac_dot_acc instance.
interface mac_dot_acc_if #(
  parameter int IN1_WIDTH = 4,
  parameter int IN2_WIDTH = 4,
  parameter int OUT_WIDTH = 12,
  parameter int CNT_WIDTH = 8
);
  logic                 IN_VALID;
  logic                 LAST;
  logic [IN1_WIDTH-1:0] A;
  logic [IN2_WIDTH-1:0] B;
  logic [OUT_WIDTH-1:0] MAC_OUT;
  logic                 OUT_VALID;
  logic [CNT_WIDTH-1:0] TERM_CNT;
  logic                 OVF;

  modport master (
    output IN_VALID, LAST, A, B,
    input  MAC_OUT, OUT_VALID, TERM_CNT, OVF
  );

  modport slave (
    input  IN_VALID, LAST, A, B,
    output MAC_OUT, OUT_VALID, TERM_CNT, OVF
  );
endinterface

// File: rtl/mac_dot_acc.sv
// mac_dot_acc: pipelined per-frame multiply-accumulate.
//   A stream of (A,B) terms framed by IN_VALID/LAST is reduced to sum(A*B);
//   one result per frame is emitted with a single-cycle OUT_VALID pulse.
// Ports:
//   SYS_CLK    clock, rising edge
//   SYS_RST_N  asynchronous active-low reset
//   SCLR       synchronous clear / pipeline flush (wins over IN_VALID)
//   bus        mac_dot_acc_if.slave: IN_VALID, LAST, A, B in;
//              MAC_OUT, OUT_VALID, TERM_CNT, OVF out
// Pipeline: input capture (edge n) -> product P (n+1) -> accumulate/FSM (n+2).
// Build option: MAC_SAT_EN defined -> saturating accumulation with sticky OVF;
//   otherwise results wrap modulo 2^OUT_WIDTH and OVF is tied low.
module mac_dot_acc #(
  parameter int IN1_WIDTH = 4,
  parameter int IN2_WIDTH = 4,
  parameter int OUT_WIDTH = 12,
  parameter int CNT_WIDTH = 8,
  parameter int SIGNED    = 0
) (
  input  logic         SYS_CLK,
  input  logic         SYS_RST_N,
  input  logic         SCLR,
  mac_dot_acc_if.slave bus
);
  localparam int PW = IN1_WIDTH + IN2_WIDTH;

  generate
    if (OUT_WIDTH < PW) begin : g_width_chk
      $error("mac_dot_acc: OUT_WIDTH must be >= IN1_WIDTH+IN2_WIDTH");
    end
  endgenerate

  typedef enum logic {IDLE, ACCUM} state_e;

  // ---------------- input capture ----------------
  logic                 in_vld_d, in_vld_q;
  logic                 in_last_d, in_last_q;
  logic [IN1_WIDTH-1:0] a_d, a_q;
  logic [IN2_WIDTH-1:0] b_d, b_q;

  always_comb begin
    in_vld_d  = bus.IN_VALID & ~SCLR;
    in_last_d = bus.IN_VALID & bus.LAST & ~SCLR;  // LAST alone is ignored
    a_d       = bus.A;
    b_d       = bus.B;
  end

  // ---------------- stage 1: product ----------------
  logic [PW-1:0] a_ext, b_ext;
  logic [PW-1:0] p_d, p_q;
  logic          s1_vld_d, s1_vld_q;
  logic          s1_last_d, s1_last_q;

  // Extending both operands to PW bits first makes the low PW bits of the
  // product correct for both unsigned and two's-complement operands.
  always_comb begin
    if (SIGNED != 0) begin
      a_ext = PW'($signed(a_q));
      b_ext = PW'($signed(b_q));
    end else begin
      a_ext = PW'(a_q);
      b_ext = PW'(b_q);
    end
    p_d       = a_ext * b_ext;
    s1_vld_d  = in_vld_q & ~SCLR;
    s1_last_d = in_last_q & ~SCLR;
  end

  // ---------------- stage 2: accumulate ----------------
  logic [OUT_WIDTH-1:0] p_ext;
  logic [OUT_WIDTH-1:0] acc_sum;
  logic [OUT_WIDTH-1:0] acc_d, acc_q;
  logic [OUT_WIDTH-1:0] mac_d, mac_q;
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
  logic [CNT_WIDTH-1:0] tcnt_d, tcnt_q;
  logic                 ovld_d, ovld_q;
  state_e               state_d, state_q;

  always_comb begin
    if (SIGNED != 0) p_ext = OUT_WIDTH'($signed(p_q));
    else             p_ext = OUT_WIDTH'(p_q);
  end

`ifdef MAC_SAT_EN
  localparam logic [OUT_WIDTH-1:0] SMAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SMIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [OUT_WIDTH:0] sum_wide;
  logic               add_ovf;
  logic               ovf_d, ovf_q;    // sticky within the running frame
  logic               ovfo_d, ovfo_q;  // reported with the last result

  // One guard bit catches the carry (unsigned) or a sign flip (signed).
  always_comb begin
    if (SIGNED != 0) begin
      sum_wide = {acc_q[OUT_WIDTH-1], acc_q} + {p_ext[OUT_WIDTH-1], p_ext};
      add_ovf  = sum_wide[OUT_WIDTH] ^ sum_wide[OUT_WIDTH-1];
      acc_sum  = add_ovf ? (sum_wide[OUT_WIDTH] ? SMIN : SMAX)
                         : sum_wide[OUT_WIDTH-1:0];
    end else begin
      sum_wide = {1'b0, acc_q} + {1'b0, p_ext};
      add_ovf  = sum_wide[OUT_WIDTH];
      acc_sum  = add_ovf ? {OUT_WIDTH{1'b1}} : sum_wide[OUT_WIDTH-1:0];
    end
  end
`else
  assign acc_sum = acc_q + p_ext;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mac_d   = mac_q;
    tcnt_d  = tcnt_q;
    ovld_d  = 1'b0;
`ifdef MAC_SAT_EN
    ovf_d   = ovf_q;
    ovfo_d  = ovfo_q;
`endif
    if (s1_vld_q) begin
      if (state_q == IDLE) begin
        acc_d = p_ext;
        cnt_d = CNT_WIDTH'(1);
`ifdef MAC_SAT_EN
        ovf_d = 1'b0;
`endif
      end else begin
        acc_d = acc_sum;
        cnt_d = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + 1'b1;
`ifdef MAC_SAT_EN
        ovf_d = ovf_q | add_ovf;
`endif
      end
      if (s1_last_q) begin
        state_d = IDLE;
        mac_d   = acc_d;
        tcnt_d  = cnt_d;
        ovld_d  = 1'b1;
`ifdef MAC_SAT_EN
        ovfo_d  = ovf_d;
`endif
      end else begin
        state_d = ACCUM;
      end
    end
    if (SCLR) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      mac_d   = '0;
      tcnt_d  = '0;
      ovld_d  = 1'b0;
`ifdef MAC_SAT_EN
      ovf_d   = 1'b0;
      ovfo_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      in_vld_q  <= 1'b0;
      in_last_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      p_q       <= '0;
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      mac_q     <= '0;
      tcnt_q    <= '0;
      ovld_q    <= 1'b0;
`ifdef MAC_SAT_EN
      ovf_q     <= 1'b0;
      ovfo_q    <= 1'b0;
`endif
    end else begin
      in_vld_q  <= in_vld_d;
      in_last_q <= in_last_d;
      a_q       <= a_d;
      b_q       <= b_d;
      s1_vld_q  <= s1_vld_d;
      s1_last_q <= s1_last_d;
      p_q       <= p_d;
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      mac_q     <= mac_d;
      tcnt_q    <= tcnt_d;
      ovld_q    <= ovld_d;
`ifdef MAC_SAT_EN
      ovf_q     <= ovf_d;
      ovfo_q    <= ovfo_d;
`endif
    end
  end

  assign bus.MAC_OUT   = mac_q;
  assign bus.OUT_VALID = ovld_q;
  assign bus.TERM_CNT  = tcnt_q;
`ifdef MAC_SAT_EN
  assign bus.OVF       = ovfo_q;
`else
  assign bus.OVF       = 1'b0;
`endif
endmodule

// File: tb/tb_mac_dot_acc.sv
// tb_mac_dot_acc: scoreboard bench for mac_dot_acc. Three instances share one
// operand stream: u0 unsigned/12b, u1 signed/12b, u2 unsigned/8b. Expected
// results (cycle, MAC_OUT, TERM_CNT, OVF per instance) are queued when LAST is
// driven and popped when OUT_VALID fires. Honours MAC_SAT_EN like the RTL.
module tb_mac_dot_acc;
  localparam int N = 3;
`ifdef MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sclr = 1'b0;
  logic       in_valid = 1'b0;
  logic       last = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int exp_q[$];
  int vcyc_q[$];

  int ow[N] = '{12, 12, 8};
  bit sg[N] = '{1'b0, 1'b1, 1'b0};
  longint m_acc[N];
  int     m_cnt[N];
  bit     m_ovf[N];
  bit     m_busy = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_dot_acc_if #(.OUT_WIDTH(12)) if0 ();
  mac_dot_acc_if #(.OUT_WIDTH(12)) if1 ();
  mac_dot_acc_if #(.OUT_WIDTH(8))  if2 ();

  assign if0.IN_VALID = in_valid;
  assign if0.LAST     = last;
  assign if0.A        = a;
  assign if0.B        = b;
  assign if1.IN_VALID = in_valid;
  assign if1.LAST     = last;
  assign if1.A        = a;
  assign if1.B        = b;
  assign if2.IN_VALID = in_valid;
  assign if2.LAST     = last;
  assign if2.A        = a;
  assign if2.B        = b;

  mac_dot_acc u0 (.SYS_CLK(clk), .SYS_RST_N(rst_n), .SCLR(sclr), .bus(if0.slave));
  mac_dot_acc #(.SIGNED(1)) u1 (.SYS_CLK(clk), .SYS_RST_N(rst_n), .SCLR(sclr), .bus(if1.slave));
  mac_dot_acc #(.OUT_WIDTH(8)) u2 (.SYS_CLK(clk), .SYS_RST_N(rst_n), .SCLR(sclr), .bus(if2.slave));

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Integer reference: exact sum, then wrap or clamp into the OUT_WIDTH range.
  task automatic model_term(input int ta, input int tb_, input bit tl);
    for (int k = 0; k < N; k++) begin
      longint p, s, lo, hi, m;
      m  = longint'(1) << ow[k];
      lo = sg[k] ? -(m / 2) : 0;
      hi = sg[k] ? (m / 2 - 1) : (m - 1);
      if (sg[k]) p = longint'(ta >= 8 ? ta - 16 : ta) * longint'(tb_ >= 8 ? tb_ - 16 : tb_);
      else       p = longint'(ta) * longint'(tb_);
      if (!m_busy) begin
        s = p;
        m_cnt[k] = 1;
        m_ovf[k] = 1'b0;
      end else begin
        s = m_acc[k] + p;
        if (m_cnt[k] < 255) m_cnt[k]++;
        if (s > hi || s < lo) begin
          if (SAT) begin
            m_ovf[k] = 1'b1;
            s = (s > hi) ? hi : lo;
          end else begin
            s = ((s - lo) % m + m) % m + lo;
          end
        end
      end
      m_acc[k] = s;
    end
    m_busy = !tl;
    if (tl) begin
      exp_q.push_back(cyc + 3);
      for (int k = 0; k < N; k++) begin
        exp_q.push_back(int'(m_acc[k] & ((longint'(1) << ow[k]) - 1)));
        exp_q.push_back(m_cnt[k]);
        exp_q.push_back(int'(m_ovf[k]));
      end
    end
  endtask

  task automatic drive(input bit v, input bit l, input int av, input int bv);
    @(posedge clk);
    #1;
    in_valid = v;
    last     = l;
    a        = 4'(av);
    b        = 4'(bv);
    if (v) model_term(av & 15, bv & 15, l);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 0, 0);
  endtask

  // Monitor: every OUT_VALID must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (if0.OUT_VALID || if1.OUT_VALID || if2.OUT_VALID)) begin
      if (exp_q.size() < 10) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        int ecyc, m0, c0, o0, m1, c1, o1, m2, c2, o2;
        ecyc = exp_q.pop_front();
        m0 = exp_q.pop_front(); c0 = exp_q.pop_front(); o0 = exp_q.pop_front();
        m1 = exp_q.pop_front(); c1 = exp_q.pop_front(); o1 = exp_q.pop_front();
        m2 = exp_q.pop_front(); c2 = exp_q.pop_front(); o2 = exp_q.pop_front();
        vcyc_q.push_back(cyc);
        chk("latency", cyc, ecyc);
        chk("vld0", if0.OUT_VALID, 1);
        chk("vld1", if1.OUT_VALID, 1);
        chk("vld2", if2.OUT_VALID, 1);
        chk("mac0", if0.MAC_OUT, m0);
        chk("cnt0", if0.TERM_CNT, c0);
        chk("ovf0", if0.OVF, o0);
        chk("mac1", if1.MAC_OUT, m1);
        chk("cnt1", if1.TERM_CNT, c1);
        chk("ovf1", if1.OVF, o1);
        chk("mac2", if2.MAC_OUT, m2);
        chk("cnt2", if2.TERM_CNT, c2);
        chk("ovf2", if2.OVF, o2);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mac", if0.MAC_OUT, 0);
    chk("rst_vld", if0.OUT_VALID, 0);
    chk("rst_cnt", if0.TERM_CNT, 0);
    chk("rst_ovf", if2.OVF, 0);
    @(negedge clk) rst_n = 1'b1;
    idle(2);

    // three-term unsigned frame
    drive(1, 0, 3, 5); drive(1, 0, 2, 7); drive(1, 1, 15, 15);
    idle(5);
    chk("t2_mac", if0.MAC_OUT, 254);
    chk("t2_cnt", if0.TERM_CNT, 3);

    // back-to-back single-term frames
    drive(1, 1, 4, 6); drive(1, 1, 1, 1);
    idle(5);
    chk("t3_consecutive", vcyc_q[vcyc_q.size()-1] - vcyc_q[vcyc_q.size()-2], 1);
    chk("t3_mac", if0.MAC_OUT, 1);

    // gapped frame aborted by SCLR; a valid LAST term in the SCLR cycle is discarded
    drive(1, 0, 1, 2); idle(1); drive(1, 0, 3, 3); idle(2);
    @(posedge clk); #1;
    sclr = 1'b1; in_valid = 1'b1; last = 1'b1; a = 4'd9; b = 4'd9;
    m_busy = 1'b0;
    @(posedge clk); #1;
    sclr = 1'b0; in_valid = 1'b0; last = 1'b0;
    chk("sclr_mac", if0.MAC_OUT, 0);
    chk("sclr_cnt", if0.TERM_CNT, 0);
    chk("sclr_vld", if0.OUT_VALID, 0);
    idle(4);
    drive(1, 1, 2, 2);
    idle(5);
    chk("t4_mac", if0.MAC_OUT, 4);

    // signed extreme operand
    drive(1, 1, 8, 7);
    idle(5);
    chk("t5_mac_signed", if1.MAC_OUT, 12'hFC8);
    chk("t5_ovf_signed", if1.OVF, 0);

    // narrow accumulator overflow
    drive(1, 0, 15, 15); drive(1, 1, 15, 15);
    idle(5);
    chk("t6_mac8", if2.MAC_OUT, SAT ? 255 : 194);
    chk("t6_ovf8", if2.OVF, SAT ? 1 : 0);

    // signed positive and negative overflow
    for (int i = 0; i < 45; i++) drive(1, i == 44, 7, 7);
    idle(4);
    for (int i = 0; i < 40; i++) drive(1, i == 39, 8, 7);
    idle(4);

    // long frame: term counter saturates at 255
    for (int i = 0; i < 260; i++) begin
      if (i % 50 == 7) idle(2);
      drive(1, i == 259, 1, 1);
    end
    idle(5);
    chk("cnt_sat", if0.TERM_CNT, 255);
    chk("long_mac8", if2.MAC_OUT, SAT ? 255 : 4);

    // random frames with random gaps and LAST-without-valid noise
    for (int f = 0; f < 8; f++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int t = 0; t < len; t++) begin
        if ($urandom_range(0, 2) == 0) drive(0, 1, 0, 0);
        drive(1, t == len - 1, $urandom_range(0, 15), $urandom_range(0, 15));
      end
    end
    idle(5);

    // asynchronous reset in the middle of a frame
    drive(1, 1, 3, 3);
    idle(5);
    chk("pre_rst_mac", if0.MAC_OUT, 9);
    drive(1, 0, 5, 5); drive(1, 0, 5, 5);
    @(posedge clk); #2;
    rst_n = 1'b0; in_valid = 1'b0; last = 1'b0;
    m_busy = 1'b0;
    #1;
    chk("arst_mac", if0.MAC_OUT, 0);
    chk("arst_cnt", if0.TERM_CNT, 0);
    chk("arst_vld", if0.OUT_VALID, 0);
    chk("arst_ovf", if2.OVF, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(6);

    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
